pe_result_reducer: RTL
======================

// Module: pe_result_reducer
// PURPOSE
//   Consumer side of the PE group result bus. Takes one packed beat of para_deg
//   lane products per handshake and sums the lanes through an adder tree.
//   Accumulates beats until in_last, then presents one scalar dot product.
//   Sits between the PE group output and the result writeback/host interface.
// PARAMETERS
//   data_width  8   operand width; each lane is 2*data_width bits, unsigned
//   para_deg    4   lanes per beat (power of 2, >=2)
//   acc_width   32  accumulator/output width; must be >= 2*data_width+clog2(para_deg)
// PORTS
//   clk        in   1                      rising-edge clock
//   reset      in   1                      synchronous, active-high
//   lanes_in   in   para_deg*2*data_width  lane i at [2*data_width*i +: 2*data_width]
//   in_valid   in   1                      beat on lanes_in is valid
//   in_last    in   1                      beat is the final beat of a vector
//   in_ready   out  1                      reducer accepts a beat this cycle
//   out_data   out  acc_width              completed dot product
//   out_beats  out  16                     beats accumulated into out_data
//   out_ovf    out  1                      accumulation overflowed acc_width
//   out_valid  out  1                      out_data/out_beats/out_ovf valid
//   out_ready  in   1                      downstream takes the result
// BEHAVIOUR
// - Reset: in_ready=1, out_valid=0, out_data=0, out_beats=0, out_ovf=0, acc=0,
//   beat count=0, stage-1 empty, state IDLE. Reset wins over every other event
//   and discards partial vectors and held results.
// - Accept = in_valid & in_ready. in_ready = ~out_valid & ~(s1_valid & s1_last).
// - Stage 1: on accept, register lane sum (2*data_width+clog2(para_deg) bits,
//   zero-extended, no truncation) plus last flag; s1_valid=1. Otherwise s1_valid=0.
// - Stage 2: when s1_valid, acc <= acc + s1_sum; beat count +1 (saturates at 0xFFFF).
//   Carry out of acc_width sets sticky ovf for the current vector.
// - When s1_valid & s1_last: the final sum, count and ovf load into the out regs;
//   out_valid=1; acc, count and ovf clear the same cycle.
// - Latency: last beat accepted in cycle T -> out_valid=1 in cycle T+2.
// - out_valid holds with out_* stable until out_valid & out_ready. On that cycle
//   out_valid=0; in_ready rises the next cycle. No output skid buffer.
// - FSM: IDLE (acc empty) -> ACCUM on a non-last accept; IDLE/ACCUM -> DRAIN on
//   a last accept; DRAIN -> HOLD (out_valid=1); HOLD -> IDLE on out handshake.
// - Single-beat vector (in_last on first beat) is legal: out_data = lane sum.
// - in_valid low between beats of a vector is legal; acc is preserved.
// - in_last with in_ready low is ignored (no accept); upstream must hold the beat.
// CONFIGURATION
//   REDUCER_SATURATE_EN defined: on overflow acc clamps to 2^acc_width-1 and
//     stays clamped for the rest of the vector; out_ovf=1.
//   Not defined: acc wraps modulo 2^acc_width; out_ovf still reports the wrap.
// TESTING (data_width=8, para_deg=4, acc_width=32 unless stated)
// 1 reset, then beat {4,3,2,1} with in_last -> out_data=10, out_beats=1, out_ovf=0,
//   out_valid at T+2, in_ready=0 until handshake
// 2 three beats of all lanes 65025, last on beat 3, valid gaps of 2 cycles ->
//   out_data=780300, out_beats=3
// 3 out_ready=0 for 5 cycles after out_valid -> out_* stable, in_ready=0;
//   out_ready=1 -> out_valid=0, in_ready=1 the next cycle, next vector accepted
// 4 reset asserted after 2 non-last beats, then beat {1,1,1,1} last ->
//   out_data=4, out_beats=1 (no residue)
// 5 acc_width=18, two beats of all lanes 65025 (260100 each), last on 2 ->
//   with REDUCER_SATURATE_EN out_data=262143; without 258056; out_ovf=1 in both
// 6 back-to-back vectors, in_valid held high, out_ready=1 -> each result correct,
//   no beat lost or double-counted across the DRAIN/HOLD bubble

Source files
------------

// File: rtl/pe_result_reducer.sv
// Sums para_deg unsigned lane products per accepted beat and accumulates beats
// into one dot product per vector. Optional build macro: REDUCER_SATURATE_EN.
module pe_result_reducer #(
   parameter int data_width = 8,
   parameter int para_deg   = 4,
   parameter int acc_width  = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [para_deg*2*data_width-1:0]   lanes_in,
   input  logic                               in_valid,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic [acc_width-1:0]               out_data,
   output logic [15:0]                        out_beats,
   output logic                               out_ovf,
   output logic                               out_valid,
   input  logic                               out_ready
);

   localparam int lane_w = 2 * data_width;
   localparam int sum_w  = lane_w + $clog2(para_deg);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   state_t               state_r;
   logic                 accept_s;
   logic [sum_w-1:0]     lane_sum_s;
   logic                 s1_valid_r;
   logic                 s1_last_r;
   logic [sum_w-1:0]     s1_sum_r;
   logic [acc_width-1:0] acc_r;
   logic [15:0]          cnt_r;
   logic                 ovf_r;
   logic [acc_width:0]   add_s;
   logic [acc_width-1:0] acc_next_s;
   logic [15:0]          cnt_next_s;
   logic                 ovf_next_s;
   logic [acc_width-1:0] out_data_r;
   logic [15:0]          out_beats_r;
   logic                 out_ovf_r;
   logic                 out_valid_r;

   // A final beat sitting in stage 1 blocks new beats until its result has drained.
   assign in_ready  = ~out_valid_r & ~(s1_valid_r & s1_last_r);
   assign accept_s  = in_valid & in_ready;
   assign out_data  = out_data_r;
   assign out_beats = out_beats_r;
   assign out_ovf   = out_ovf_r;
   assign out_valid = out_valid_r;

   // Adder tree over all lanes, widened so no lane carry is lost.
   always_comb begin
      lane_sum_s = {sum_w{1'b0}};
      for (int i = 0; i < para_deg; i++) begin
         lane_sum_s = lane_sum_s + sum_w'(lanes_in[lane_w*i +: lane_w]);
      end
   end

   // Next accumulator, beat count and sticky overflow for the stage-1 beat.
   always_comb begin
      add_s      = {1'b0, acc_r} + (acc_width+1)'(s1_sum_r);
      ovf_next_s = ovf_r | add_s[acc_width];
`ifdef REDUCER_SATURATE_EN
      if (ovf_next_s) begin
         acc_next_s = {acc_width{1'b1}};
      end else begin
         acc_next_s = add_s[acc_width-1:0];
      end
`else
      acc_next_s = add_s[acc_width-1:0];
`endif
      if (cnt_r == 16'hFFFF) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + 16'd1;
      end
   end

   // Stage 1: register the lane sum and last flag of an accepted beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_sum_r   <= {sum_w{1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_last_r  <= in_last;
         s1_sum_r   <= lane_sum_s;
      end else begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
      end
   end

   // Stage 2 accumulation, result hand-off and vector-level state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         acc_r       <= {acc_width{1'b0}};
         cnt_r       <= 16'd0;
         ovf_r       <= 1'b0;
         out_data_r  <= {acc_width{1'b0}};
         out_beats_r <= 16'd0;
         out_ovf_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         if (s1_valid_r && s1_last_r) begin
            out_data_r  <= acc_next_s;
            out_beats_r <= cnt_next_s;
            out_ovf_r   <= ovf_next_s;
            out_valid_r <= 1'b1;
            acc_r       <= {acc_width{1'b0}};
            cnt_r       <= 16'd0;
            ovf_r       <= 1'b0;
         end else if (s1_valid_r) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end

         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r <= in_last ? DRAIN : ACCUM;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCUM: begin
               if (accept_s && in_last) begin
                  state_r <= DRAIN;
               end else begin
                  state_r <= ACCUM;
               end
            end
            DRAIN: state_r <= HOLD;
            HOLD: begin
               if (out_valid_r && out_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
